// File: rtl/chord_arpeggiator.sv
// Chord arpeggiator: plays a captured 4-note chord one note per step
// in up/down/ping-pong/root pattern, with a one-deep pending chord slot.
module chord_arpeggiator #(
  parameter int STEP_TICKS = 12_500_000,
  parameter int GATE_TICKS = 9_375_000,
  parameter int CNT_W      = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic        chord_valid,
  output logic        chord_ready,
  input  logic [3:0]  chord,
  input  logic [15:0] notes_for_chord,
  output logic [3:0]  note_out,
  output logic        note_valid,
  output logic        note_strobe,
  output logic [1:0]  step_idx
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] GATE = CNT_W'(GATE_TICKS);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [1:0]       step, step_n;
  logic             dir, dir_n;
  logic             pend_full, pend_full_n;
  logic [3:0]       pend_chord, pend_chord_n;
  logic [15:0]      pend_notes, pend_notes_n;
  logic [3:0]       act_chord, act_chord_n;
  logic [15:0]      act_notes, act_notes_n;
  logic             act_loaded, act_loaded_n;
  logic             load;
  logic             sounding;
  logic [3:0]       cur_note;

  function automatic logic [15:0] reduce(input logic [15:0] n);
    logic [15:0] r;
    logic [3:0]  v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      v = n[4*i +: 4];
      r[4*i +: 4] = (v >= 4'd12) ? v - 4'd12 : v;
    end
    return r;
  endfunction

  function automatic logic [1:0] first(input logic [1:0] m);
    return (m == 2'b01) ? 2'd3 : 2'd0;
  endfunction

  always_comb begin
    state_n      = state;
    count_n      = count;
    step_n       = step;
    dir_n        = dir;
    pend_full_n  = pend_full;
    pend_chord_n = pend_chord;
    pend_notes_n = pend_notes;
    act_chord_n  = act_chord;
    act_notes_n  = act_notes;
    act_loaded_n = act_loaded;
    load         = 1'b0;
    unique case (state)
      IDLE: begin
        count_n = '0;
        if (enable && (pend_full || act_loaded)) begin
          load    = pend_full;
          state_n = PLAY;
          step_n  = first(mode);
          dir_n   = 1'b1;
        end
      end
      PLAY: begin
        if (!enable) begin
          state_n = IDLE;
          count_n = '0;
        end else if (count == LAST) begin
          count_n = '0;
          if (pend_full) begin
            load   = 1'b1;
            step_n = first(mode);
            dir_n  = 1'b1;
          end else begin
            case (mode)
              2'b00: step_n = step + 2'd1;
              2'b01: step_n = step - 2'd1;
              2'b11: step_n = 2'd0;
              default: begin
                // ping-pong bounces off both ends
                if (dir) begin
                  if (step == 2'd3) begin
                    step_n = 2'd2;
                    dir_n  = 1'b0;
                  end else begin
                    step_n = step + 2'd1;
                  end
                end else begin
                  if (step == 2'd0) begin
                    step_n = 2'd1;
                    dir_n  = 1'b1;
                  end else begin
                    step_n = step - 2'd1;
                  end
                end
              end
            endcase
          end
        end else begin
          count_n = count + CNT_W'(1);
        end
      end
    endcase
    if (load) begin
      act_chord_n  = pend_chord;
      act_notes_n  = pend_notes;
      act_loaded_n = 1'b1;
      pend_full_n  = 1'b0;
    end
    // capture only into an empty slot, so never collides with load
    if (chord_valid && !pend_full) begin
      pend_full_n  = 1'b1;
      pend_chord_n = chord;
      pend_notes_n = reduce(notes_for_chord);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      step       <= 2'd0;
      dir        <= 1'b1;
      pend_full  <= 1'b0;
      pend_chord <= 4'd0;
      pend_notes <= 16'd0;
      act_chord  <= 4'd0;
      act_notes  <= 16'd0;
      act_loaded <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      step       <= step_n;
      dir        <= dir_n;
      pend_full  <= pend_full_n;
      pend_chord <= pend_chord_n;
      pend_notes <= pend_notes_n;
      act_chord  <= act_chord_n;
      act_notes  <= act_notes_n;
      act_loaded <= act_loaded_n;
    end
  end

  always_comb begin
    cur_note = 4'd0;
    case (step)
      2'd0: cur_note = act_notes[15:12];
      2'd1: cur_note = act_notes[11:8];
      2'd2: cur_note = act_notes[7:4];
      default: cur_note = act_notes[3:0];
    endcase
  end

  assign sounding    = (state == PLAY) && (act_chord != 4'd0);
  assign note_valid  = sounding && (count < GATE);
  assign note_strobe = sounding && (count == '0);
  assign note_out    = sounding ? cur_note : 4'd0;
  assign step_idx    = step;
  assign chord_ready = !pend_full;

endmodule

// File: tb/tb_chord_arpeggiator.sv
// Testbench for chord_arpeggiator: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model.
module tb_chord_arpeggiator;
  localparam int STEP = 8;
  localparam int GATE = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        chord_valid = 1'b0;
  logic        chord_ready;
  logic [3:0]  chord = 4'd0;
  logic [15:0] notes_for_chord = 16'd0;
  logic [3:0]  note_out;
  logic        note_valid;
  logic        note_strobe;
  logic [1:0]  step_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int sq[$];

  chord_arpeggiator #(
    .STEP_TICKS(STEP),
    .GATE_TICKS(GATE),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .mode(mode),
    .chord_valid(chord_valid),
    .chord_ready(chord_ready),
    .chord(chord),
    .notes_for_chord(notes_for_chord),
    .note_out(note_out),
    .note_valid(note_valid),
    .note_strobe(note_strobe),
    .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pf;
    logic [3:0]  pc;
    logic [15:0] pn;
    logic [3:0]  ac;
    logic [15:0] an;
    logic        loaded;
    logic        play;
    int          t;
    int          idx;
    logic        up;
  } mdl_t;

  mdl_t m = '0;

  function automatic int nib(input logic [15:0] v, input int i);
    return int'(v[15-4*i -: 4]);
  endfunction

  function automatic logic [15:0] red(input logic [15:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[15-4*i -: 4] = 4'(nib(v, i) % 12);
    return r;
  endfunction

  function automatic mdl_t model_next(input mdl_t s);
    mdl_t n;
    logic cap;
    n = s;
    if (!rst_n) begin
      n = '0;
      n.up = 1'b1;
      return n;
    end
    cap = chord_valid && !s.pf;
    if (!s.play) begin
      if (enable && (s.pf || s.loaded)) begin
        if (s.pf) begin
          n.ac = s.pc; n.an = s.pn; n.pf = 1'b0; n.loaded = 1'b1;
        end
        n.play = 1'b1; n.t = 0; n.up = 1'b1;
        n.idx = (mode == 2'b01) ? 3 : 0;
      end
    end else if (!enable) begin
      n.play = 1'b0; n.t = 0;
    end else if (s.t == STEP - 1) begin
      n.t = 0;
      if (s.pf) begin
        n.ac = s.pc; n.an = s.pn; n.pf = 1'b0; n.loaded = 1'b1;
        n.idx = (mode == 2'b01) ? 3 : 0; n.up = 1'b1;
      end else if (mode == 2'b00) n.idx = (s.idx + 1) % 4;
      else if (mode == 2'b01) n.idx = (s.idx + 3) % 4;
      else if (mode == 2'b11) n.idx = 0;
      else if (s.up) begin
        if (s.idx == 3) begin n.idx = 2; n.up = 1'b0; end
        else n.idx = s.idx + 1;
      end else begin
        if (s.idx == 0) begin n.idx = 1; n.up = 1'b1; end
        else n.idx = s.idx - 1;
      end
    end else begin
      n.t = s.t + 1;
    end
    if (cap) begin
      n.pf = 1'b1; n.pc = chord; n.pn = red(notes_for_chord);
    end
    return n;
  endfunction

  function automatic logic [8:0] exp_out(input mdl_t s);
    logic snd;
    snd = s.play && (s.ac != 4'd0);
    return {!s.pf, snd && (s.t < GATE), snd && (s.t == 0),
            2'(s.idx), snd ? 4'(nib(s.an, s.idx)) : 4'd0};
  endfunction

  function automatic logic [8:0] obs();
    return {chord_ready, note_valid, note_strobe, step_idx, note_out};
  endfunction

  always @(posedge clk) m <= model_next(m);

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; chord_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [3:0] c, input logic [15:0] n);
    chord_valid = 1'b1; chord = c; notes_for_chord = n;
    tick(1);
    chord_valid = 1'b0;
  endtask

  task automatic collect(input int n);
    sq.delete();
    for (int i = 0; i < (n + 2) * STEP && sq.size() < n; i++) begin
      if (note_strobe) sq.push_back(int'(note_out));
      tick(1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if (obs() !== 9'h100) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs(), 9'h100);
    end
    n_assert++;
    if (obs() !== exp_out(m)) begin
      n_fail++;
      $display("FAIL reset_model: got %h expected %h", obs(), exp_out(m));
    end
  endtask

  task automatic test_up();
    int e[5] = '{0, 4, 7, 11, 0};
    int g, s, got;
    do_reset();
    mode = 2'b00; enable = 1'b1;
    send(4'd1, 16'h047B);
    collect(5);
    for (int i = 0; i < 5; i++) begin
      got = (i < sq.size()) ? sq[i] : -1;
      n_assert++;
      if (got !== e[i]) begin
        n_fail++;
        $display("FAIL up_note%0d: got %0d expected %0d", i, got, e[i]);
      end
    end
    g = 0; s = 0;
    for (int i = 0; i < 4 * STEP; i++) begin
      g += int'(note_valid); s += int'(note_strobe);
      tick(1);
    end
    n_assert++;
    if (g !== 4 * GATE) begin
      n_fail++;
      $display("FAIL up_gate_cycles: got %0d expected %0d", g, 4 * GATE);
    end
    n_assert++;
    if (s !== 4) begin
      n_fail++;
      $display("FAIL up_strobes: got %0d expected %0d", s, 4);
    end
  endtask

  task automatic test_pingpong();
    int e[8] = '{1, 5, 9, 0, 9, 5, 1, 5};
    int d[4] = '{0, 9, 5, 1};
    int got;
    do_reset();
    mode = 2'b10; enable = 1'b1;
    send(4'd2, 16'h159C);
    collect(8);
    for (int i = 0; i < 8; i++) begin
      got = (i < sq.size()) ? sq[i] : -1;
      n_assert++;
      if (got !== e[i]) begin
        n_fail++;
        $display("FAIL pp_note%0d: got %0d expected %0d", i, got, e[i]);
      end
    end
    do_reset();
    mode = 2'b01; enable = 1'b1;
    send(4'd2, 16'h159C);
    collect(4);
    for (int i = 0; i < 4; i++) begin
      got = (i < sq.size()) ? sq[i] : -1;
      n_assert++;
      if (got !== d[i]) begin
        n_fail++;
        $display("FAIL down_note%0d: got %0d expected %0d", i, got, d[i]);
      end
    end
  endtask

  task automatic test_pending();
    int e[5] = '{2, 4, 6, 8, 2};
    int got;
    do_reset();
    mode = 2'b00; enable = 1'b1;
    send(4'd3, 16'h047B);
    collect(3);
    tick(1);
    send(4'd4, 16'h2468);
    n_assert++;
    if (chord_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_ready_low: got %b expected 0", chord_ready);
    end
    send(4'd5, 16'h9999);
    n_assert++;
    if ({chord_ready, note_out} !== {1'b0, 4'd7}) begin
      n_fail++;
      $display("FAIL pend_hold: got %b/%0d expected 0/7", chord_ready, note_out);
    end
    collect(5);
    for (int i = 0; i < 5; i++) begin
      got = (i < sq.size()) ? sq[i] : -1;
      n_assert++;
      if (got !== e[i]) begin
        n_fail++;
        $display("FAIL pend_note%0d: got %0d expected %0d", i, got, e[i]);
      end
    end
    n_assert++;
    if (chord_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_ready_high: got %b expected 1", chord_ready);
    end
  endtask

  task automatic test_rest();
    int act, got;
    do_reset();
    mode = 2'b00; enable = 1'b1;
    send(4'd0, 16'h047B);
    tick(1);
    act = 0;
    for (int i = 0; i < 4 * STEP; i++) begin
      act += int'(note_valid) + int'(note_strobe);
      if (i % STEP == 0) begin
        n_assert++;
        if (step_idx !== 2'(i / STEP)) begin
          n_fail++;
          $display("FAIL rest_step%0d: got %0d expected %0d", i / STEP, step_idx, i / STEP);
        end
      end
      tick(1);
    end
    n_assert++;
    if (act !== 0) begin
      n_fail++;
      $display("FAIL rest_silent: got %0d expected 0", act);
    end
    send(4'd6, 16'h1234);
    collect(1);
    got = (sq.size() > 0) ? sq[0] : -1;
    n_assert++;
    if (got !== 1) begin
      n_fail++;
      $display("FAIL rest_resume: got %0d expected 1", got);
    end
  endtask

  task automatic test_enable();
    do_reset();
    mode = 2'b00; enable = 1'b1;
    send(4'd1, 16'h047B);
    collect(1);
    tick(2);
    enable = 1'b0;
    tick(1);
    n_assert++;
    if ({note_valid, note_strobe} !== 2'b00) begin
      n_fail++;
      $display("FAIL en_drop: got %b expected 00", {note_valid, note_strobe});
    end
    enable = 1'b1;
    tick(1);
    n_assert++;
    if ({note_strobe, note_out} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL en_up_restart: got %b/%0d expected 1/0", note_strobe, note_out);
    end
    enable = 1'b0;
    tick(1);
    mode = 2'b01; enable = 1'b1;
    tick(1);
    n_assert++;
    if ({note_strobe, step_idx, note_out} !== {1'b1, 2'd3, 4'd11}) begin
      n_fail++;
      $display("FAIL en_down_restart: got %b/%0d/%0d expected 1/3/11",
               note_strobe, step_idx, note_out);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    do_reset();
    mode = 2'b00; enable = 1'b1;
    send(4'd1, 16'h047B);
    collect(1);
    rst_n = 1'b0;
    tick(1);
    n_assert++;
    if (obs() !== 9'h100) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected %h", obs(), 9'h100);
    end
    rst_n = 1'b1;
    s = 0;
    for (int i = 0; i < 3 * STEP; i++) begin
      s += int'(note_strobe) + int'(note_valid);
      tick(1);
    end
    n_assert++;
    if (s !== 0) begin
      n_fail++;
      $display("FAIL midreset_silent: got %0d expected 0", s);
    end
    send(4'd7, 16'h5000);
    collect(1);
    n_assert++;
    if (sq.size() !== 1 || sq[0] !== 5) begin
      n_fail++;
      $display("FAIL midreset_replay: got %0d strobes expected 1 with note 5", sq.size());
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      n_assert++;
      if (obs() !== exp_out(m)) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL rand_cycle%0d: got %h expected %h", i, obs(), exp_out(m));
      end
      chord_valid = ($urandom_range(0, 9) == 0);
      chord = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      notes_for_chord = 16'($urandom);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      if (enable) enable = ($urandom_range(0, 59) != 0);
      else enable = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up();
    test_pingpong();
    test_pending();
    test_rest();
    test_enable();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
